// File: rtl/vip_axi4_burst_addr_gen.sv
// vip_axi4_burst_addr_gen
//   Takes one AW/AR-style request, checks it against the AXI4 burst rules and
//   then emits one per-beat descriptor (address, byte lane, index, last) for
//   each beat_valid/beat_ready handshake. Supports FIXED, INCR and WRAP bursts.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_id/addr/len/size/burst      AXI request fields
//   beat_valid/beat_ready           beat descriptor handshake
//   beat_id/addr/lane/index/last    per-beat descriptor
//   err_valid/err_code              one-cycle reject pulse with reason bits
//                                   (0 reserved burst, 1 illegal WRAP,
//                                    2 size wider than bus, 3 4 KB crossing)
//
// Configuration
//   VIP_AXI4_BURST_4K_CHECK_EN      when defined, INCR bursts that cross a
//                                   4 KB boundary are rejected (err_code[3]);
//                                   otherwise err_code[3] is always 0.
module vip_axi4_burst_addr_gen #(
  parameter int ID_WIDTH_P   = 4,
  parameter int ADDR_WIDTH_P = 32,
  parameter int DATA_WIDTH_P = 64,
  localparam int BUS_BYTES   = DATA_WIDTH_P / 8,
  localparam int LANE_W      = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ID_WIDTH_P-1:0]   req_id,
  input  logic [ADDR_WIDTH_P-1:0] req_addr,
  input  logic [7:0]              req_len,
  input  logic [2:0]              req_size,
  input  logic [1:0]              req_burst,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [ID_WIDTH_P-1:0]   beat_id,
  output logic [ADDR_WIDTH_P-1:0] beat_addr,
  output logic [LANE_W-1:0]       beat_lane,
  output logic [7:0]              beat_index,
  output logic                    beat_last,
  output logic                    err_valid,
  output logic [3:0]              err_code
);

  typedef logic [ADDR_WIDTH_P-1:0] addr_t;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [2:0] MAX_SIZE    = 3'($clog2(BUS_BYTES));

  function automatic addr_t size_bytes(input logic [2:0] size);
    return addr_t'(1) << size;
  endfunction

  function automatic addr_t align_down(input addr_t a, input addr_t s);
    return a & ~(s - addr_t'(1));
  endfunction

  // WRAP addresses are always size-aligned, so align+S is also their plain
  // increment; only the upper-bound fold-back differs from INCR.
  function automatic addr_t next_addr(input addr_t a, input logic [2:0] size,
                                      input logic [1:0] burst,
                                      input addr_t lower, input addr_t upper);
    addr_t s;
    addr_t n;
    addr_t r;
    s = size_bytes(size);
    n = align_down(a, s) + s;
    case (burst)
      BURST_FIXED: r = a;
      BURST_WRAP:  r = (n == upper) ? lower : n;
      default:     r = n;
    endcase
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [ID_WIDTH_P-1:0]   id_q;
  addr_t                   addr_q;
  addr_t                   lower_q;
  addr_t                   upper_q;
  logic [7:0]              len_q;
  logic [7:0]              index_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_valid_q;
  logic [3:0]              err_code_q;

  logic                    req_fire;
  logic                    beat_fire;
  logic [3:0]              req_err;
  addr_t                   req_s;
  addr_t                   wrap_w;
  addr_t                   wrap_lower;

  assign req_ready = (state_q == IDLE);
  assign req_fire  = req_valid && req_ready;
  assign beat_fire = beat_valid && beat_ready;

  assign req_s      = size_bytes(req_size);
  assign wrap_w     = (addr_t'(req_len) + addr_t'(1)) << req_size;
  assign wrap_lower = align_down(req_addr, wrap_w);

`ifdef VIP_AXI4_BURST_4K_CHECK_EN
  // One extra bit so a burst running off the top of the address space is
  // also seen as leaving the starting 4 KB page.
  logic [ADDR_WIDTH_P:0] incr_last;
  logic                  crosses_4k;
  assign incr_last  = {1'b0, align_down(req_addr, req_s)}
                    + (({1'b0, addr_t'(req_len)} + 1'b1) << req_size)
                    - 1'b1;
  assign crosses_4k = (incr_last >> 12) != ({1'b0, req_addr} >> 12);
`endif

  always_comb begin
    req_err    = '0;
    req_err[0] = (req_burst == BURST_RSVD);
    req_err[1] = (req_burst == BURST_WRAP) &&
                 (!(req_len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                  ((req_addr & (req_s - addr_t'(1))) != '0));
    req_err[2] = (req_size > MAX_SIZE);
`ifdef VIP_AXI4_BURST_4K_CHECK_EN
    req_err[3] = (req_burst == BURST_INCR) && crosses_4k;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire && (req_err == '0)) state_d = ACTIVE;
      ACTIVE:  if (beat_fire && beat_last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q        <= '0;
      addr_q      <= '0;
      lower_q     <= '0;
      upper_q     <= '0;
      len_q       <= '0;
      index_q     <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      err_valid_q <= req_fire && (req_err != '0);
      if (req_fire && (req_err != '0)) err_code_q <= req_err;
      if (req_fire && (req_err == '0)) begin
        id_q    <= req_id;
        addr_q  <= req_addr;
        lower_q <= wrap_lower;
        upper_q <= wrap_lower + wrap_w;
        len_q   <= req_len;
        index_q <= '0;
        size_q  <= req_size;
        burst_q <= req_burst;
      end else if (beat_fire) begin
        addr_q  <= next_addr(addr_q, size_q, burst_q, lower_q, upper_q);
        index_q <= index_q + 8'd1;
      end
    end
  end

  assign beat_valid = (state_q == ACTIVE);
  assign beat_id    = id_q;
  assign beat_addr  = addr_q;
  assign beat_index = index_q;
  assign beat_last  = beat_valid && (index_q == len_q);
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;

  generate
    if (BUS_BYTES > 1) begin : g_lane
      assign beat_lane = addr_q[LANE_W-1:0];
    end else begin : g_lane_narrow
      assign beat_lane = '0;
    end
  endgenerate

endmodule
